eaglesong_sponge_ctrl: RTL and testbench
========================================

# eaglesong_sponge_ctrl

Sponge controller for the Eaglesong hash. It sits directly upstream of `eaglesong_permutation`. It packs big-endian 32-bit message words into the 256-bit rate (state words 0..7) and applies delimiter padding. For each block it launches the permutation, and it presents the 256-bit digest once the final block has been permuted. The 16×32-bit state register lives here; the permutation is treated as a multi-cycle engine with a start/ready handshake.

## Interface

Parameters:
- `DELIM`, default `8'h06`: Eaglesong domain delimiter byte appended after the last message byte.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high; clears all state.
- `msg_word` input 32: message word; byte 0 is `[31:24]`, byte 3 is `[7:0]`.
- `msg_valid` input 1: `msg_word` is valid.
- `msg_last` input 1: this is the final message word.
- `msg_nbytes` input 3: valid bytes in the last word, 0..4; only sampled with `msg_last`; values >4 are treated as 4.
- `msg_ready` output 1: controller accepts a word this cycle.
- `perm_state_out` output 32×[15:0]: current state to the permutation's `state_input`.
- `perm_start` output 1: one-cycle pulse to the permutation's `start_eval`.
- `perm_state_in` input 32×[15:0]: the permutation's `state_output`.
- `perm_done` input 1: the permutation's `eval_output_ready`.
- `digest` output 256: state words 0..7 concatenated, word 0 in `[255:224]`.
- `digest_valid` output 1: digest is available.
- `digest_ready` input 1: consumer accepts the digest.

## Operation

- **States:** ABSORB, PAD, PERM_START, PERM_WAIT, DONE.
- **Internal registers:** `word_cnt` (0..7), `final` flag, `pad_pending` flag.
- **Word accept:** a word is accepted when `msg_valid && msg_ready`.
- **ABSORB:** `msg_ready` = 1. On accept, XOR `msg_word` into `state[word_cnt]`.
  - Not last: increment `word_cnt`. If `word_cnt` was 7, go to PERM_START with `word_cnt` = 0.
  - Last with n = `msg_nbytes` < 4: bytes ≥ n are masked to zero and `DELIM` is placed at byte n. Set `final`, go to PERM_START.
  - Last with n = 4 and `word_cnt` < 7: increment `word_cnt`, go to PAD.
  - Last with n = 4 and `word_cnt` = 7: set `pad_pending`, go to PERM_START with `word_cnt` = 0.
- **PAD:** for one cycle, XOR `{DELIM, 24'h0}` into `state[word_cnt]`. Set `final`, clear `pad_pending`, go to PERM_START.
- **PERM_START:** `perm_start` = 1 for exactly this cycle; go to PERM_WAIT.
- **PERM_WAIT:** on the first cycle with `perm_done` = 1, load all 16 words from `perm_state_in`. Then:
  - if `final`: go to DONE;
  - else if `pad_pending`: go to PAD;
  - else: go to ABSORB.
- **DONE:** `digest_valid` = 1, `digest` is stable. On `digest_ready`:
  - clear the state to all zero and clear `word_cnt`, `final` and `pad_pending`;
  - go to ABSORB.
- **Spurious `perm_done`:** ignored in any state other than PERM_WAIT.
- **`msg_valid` outside ABSORB:** ignored; the word is not consumed.
- **Capacity words 8..15:** never written from the message side.

## Timing

- **Reset values:** state = 0, FSM = ABSORB, `word_cnt` = 0, flags = 0. `msg_ready`, `perm_start` and `digest_valid` are 0 while `reset` is high.
- **`msg_ready` after reset:** 1 on the first cycle after `reset` deasserts.
- **Output decode:** `msg_ready`, `perm_start` and `digest_valid` are decoded from the registered FSM state, with no combinational input-to-output path.
- **Block-ending word:** `perm_start` pulses on the cycle after the accept of the 8th word of a block, or of a last word with n < 4.
- **Last word, n = 4, `word_cnt` < 7:** PAD takes one cycle, so `perm_start` pulses 2 cycles after the accept.
- **`perm_state_out`:** held constant from PERM_START through the cycle `perm_done` is sampled.
- **Digest latency:** `digest_valid` rises the cycle after `perm_done` is sampled for the final block.
- **Next message:** ABSORB (`msg_ready` = 1) begins the cycle after the `digest_ready` accept.
- **Throughput:** 8 accept cycles + 1 + permutation latency per block.
- **Reset mid-operation:** reset in any state returns everything to reset values on the next edge. A `perm_done` arriving after that is ignored.
- **Simultaneous `digest_ready` and `msg_valid` in DONE:** the word is not accepted in that cycle.

## Test plan

The bench uses a stub permutation: it returns `perm_state_out[i] ^ (32'h1000_0000 + i)`, with `perm_done` raised a programmable 1..20 cycles after `perm_start`.

- **Empty message** (`msg_last`, n = 0, first word): `perm_start` next cycle with `state[0]` = `32'h06000000`, all other words 0. Digest word 0 = `32'h16000000`, word k = `32'h10000000+k`.
- **"abc"** (`msg_word` = `32'h616263FF`, last, n = 3): `state[0]` = `32'h61626306` at `perm_start` (byte 3 masked). One `perm_start` total.
- **Exactly 8 full words, last n = 4:**
  - first perm then `pad_pending`;
  - second block `state[0]` = `32'h06000000 ^` (stub output word 0);
  - exactly 2 `perm_start` pulses.
- **Last word n = 4 at `word_cnt` = 2:** PAD writes `32'h06000000` into `state[3]`; `perm_start` 2 cycles after the accept.
- **Handshake checks:**
  - `perm_done` held high in ABSORB → no state change;
  - `msg_valid` held during PERM_WAIT → `msg_ready` = 0 and no word lost;
  - `digest_valid` held with `digest_ready` = 0 for 10 cycles → digest stable.
- **Reset in PERM_WAIT:** outputs return to 0, state zero. A late `perm_done` is ignored. A subsequent "abc" run gives an identical digest to the clean run.

Source files
------------

// File: rtl/eaglesong_sponge_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : eaglesong_sponge_ctrl
// Purpose  : Eaglesong sponge sequencer: absorbs big-endian words into the
//            rate, applies delimiter padding, drives the permutation engine.
// Revision : 1.0  initial release
// ============================================================================
module eaglesong_sponge_ctrl #(
   parameter logic [7:0] DELIM = 8'h06
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       msg_word,
   input  logic              msg_valid,
   input  logic              msg_last,
   input  logic [2:0]        msg_nbytes,
   output logic              msg_ready,
   output logic [15:0][31:0] perm_state_out,
   output logic              perm_start,
   input  logic [15:0][31:0] perm_state_in,
   input  logic              perm_done,
   output logic [255:0]      digest,
   output logic              digest_valid,
   input  logic              digest_ready
);

   typedef enum logic [2:0] {
      S_ABSORB     = 3'd0,
      S_PAD        = 3'd1,
      S_PERM_START = 3'd2,
      S_PERM_WAIT  = 3'd3,
      S_DONE       = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [15:0][31:0] r_st;
   logic [2:0]        r_word_cnt;
   logic              r_final;
   logic              r_pad_pending;

   logic              w_accept;
   logic              w_short_last;
   logic              w_full_last;
   logic [31:0]       w_tail_word;
   logic [31:0]       w_absorb_word;

   assign w_accept      = msg_valid && (r_state == S_ABSORB);
   assign w_short_last  = msg_last && (msg_nbytes < 3'd4);
   assign w_full_last   = msg_last && !w_short_last;
   assign w_absorb_word = w_short_last ? w_tail_word : msg_word;

   // Keep the first n bytes, drop the delimiter at byte n, zero the rest.
   always_comb begin
      w_tail_word = {DELIM, 24'h0};
      case (msg_nbytes)
         3'd1:    w_tail_word = {msg_word[31:24], DELIM, 16'h0};
         3'd2:    w_tail_word = {msg_word[31:16], DELIM, 8'h0};
         3'd3:    w_tail_word = {msg_word[31:8], DELIM};
         default: w_tail_word = {DELIM, 24'h0};
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_ABSORB;
      end else begin
         r_state <= w_next;
      end
   end

   // Handshake outputs come from the registered state only; reset forces them low.
   always_comb begin
      w_next       = r_state;
      msg_ready    = 1'b0;
      perm_start   = 1'b0;
      digest_valid = 1'b0;
      case (r_state)
         S_ABSORB: begin
            msg_ready = !reset;
            if (w_accept) begin
               if (w_short_last) begin
                  w_next = S_PERM_START;
               end else if (r_word_cnt == 3'd7) begin
                  w_next = S_PERM_START;
               end else if (w_full_last) begin
                  w_next = S_PAD;
               end
            end
         end
         S_PAD: begin
            w_next = S_PERM_START;
         end
         S_PERM_START: begin
            perm_start = !reset;
            w_next     = S_PERM_WAIT;
         end
         S_PERM_WAIT: begin
            if (perm_done) begin
               if (r_final) begin
                  w_next = S_DONE;
               end else if (r_pad_pending) begin
                  w_next = S_PAD;
               end else begin
                  w_next = S_ABSORB;
               end
            end
         end
         S_DONE: begin
            digest_valid = !reset;
            if (digest_ready) begin
               w_next = S_ABSORB;
            end
         end
         default: begin
            w_next = S_ABSORB;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_st          <= '0;
         r_word_cnt    <= 3'd0;
         r_final       <= 1'b0;
         r_pad_pending <= 1'b0;
      end else begin
         case (r_state)
            S_ABSORB: begin
               if (w_accept) begin
                  r_st[r_word_cnt] <= r_st[r_word_cnt] ^ w_absorb_word;
                  if (w_short_last) begin
                     r_final <= 1'b1;
                  end else begin
                     // Wraps 7 -> 0 at the end of a block.
                     r_word_cnt <= r_word_cnt + 3'd1;
                     if (w_full_last && (r_word_cnt == 3'd7)) begin
                        r_pad_pending <= 1'b1;
                     end
                  end
               end
            end
            S_PAD: begin
               r_st[r_word_cnt] <= r_st[r_word_cnt] ^ {DELIM, 24'h0};
               r_final          <= 1'b1;
               r_pad_pending    <= 1'b0;
            end
            S_PERM_WAIT: begin
               if (perm_done) begin
                  r_st <= perm_state_in;
               end
            end
            S_DONE: begin
               if (digest_ready) begin
                  r_st          <= '0;
                  r_word_cnt    <= 3'd0;
                  r_final       <= 1'b0;
                  r_pad_pending <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign perm_state_out = r_st;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_digest
         assign digest[255 - 32*gi -: 32] = r_st[gi];
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_eaglesong_sponge_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_eaglesong_sponge_ctrl
// Purpose  : Scoreboard bench for eaglesong_sponge_ctrl with a stub permutation.
// Revision : 1.0  initial release
// ============================================================================
module tb_eaglesong_sponge_ctrl;

   localparam logic [7:0] DELIM = 8'h06;

   logic              clk = 1'b0;
   logic              reset;
   logic [31:0]       msg_word;
   logic              msg_valid;
   logic              msg_last;
   logic [2:0]        msg_nbytes;
   logic              msg_ready;
   logic [15:0][31:0] perm_state_out;
   logic              perm_start;
   logic [15:0][31:0] perm_state_in;
   logic              perm_done;
   logic [255:0]      digest;
   logic              digest_valid;
   logic              digest_ready;

   logic              stub_done;
   logic              spur_done;
   int                stub_lat;

   int                checks   = 0;
   int                failures = 0;
   int                blk_seen = 0;
   logic [15:0][31:0] exp_pre[$];
   logic [255:0]      exp_dig[$];
   int                exp_blk[$];

   eaglesong_sponge_ctrl #(.DELIM(DELIM)) dut (
      .clk            (clk),
      .reset          (reset),
      .msg_word       (msg_word),
      .msg_valid      (msg_valid),
      .msg_last       (msg_last),
      .msg_nbytes     (msg_nbytes),
      .msg_ready      (msg_ready),
      .perm_state_out (perm_state_out),
      .perm_start     (perm_start),
      .perm_state_in  (perm_state_in),
      .perm_done      (perm_done),
      .digest         (digest),
      .digest_valid   (digest_valid),
      .digest_ready   (digest_ready)
   );

   always #5 clk = ~clk;

   assign perm_done = stub_done | spur_done;

   always_comb begin
      perm_state_in = '0;
      for (int i = 0; i < 16; i++) begin
         perm_state_in[i] = perm_state_out[i] ^ (32'h1000_0000 + 32'(i));
      end
   end

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: byte stream + delimiter, zero-filled to 32-byte blocks, each
   // block XORed into the rate and then passed through the stub permutation.
   task automatic expect_msg(input logic [31:0] words[$], input logic [2:0] nb);
      logic [7:0]        b[$];
      logic [15:0][31:0] s;
      logic [255:0]      dg;
      int                n;
      int                nblk;
      n = (nb > 3'd4) ? 4 : int'(nb);
      for (int i = 0; i < words.size(); i++) begin
         for (int j = 0; j < ((i == words.size() - 1) ? n : 4); j++) begin
            b.push_back(words[i][31 - 8*j -: 8]);
         end
      end
      b.push_back(DELIM);
      while ((b.size() % 32) != 0) b.push_back(8'h00);
      nblk = b.size() / 32;
      s = '0;
      for (int k = 0; k < nblk; k++) begin
         for (int w = 0; w < 8; w++) begin
            s[w] = s[w] ^ {b[32*k + 4*w], b[32*k + 4*w + 1], b[32*k + 4*w + 2], b[32*k + 4*w + 3]};
         end
         exp_pre.push_back(s);
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ (32'h1000_0000 + 32'(i));
      end
      dg = '0;
      for (int w = 0; w < 8; w++) dg[255 - 32*w -: 32] = s[w];
      exp_dig.push_back(dg);
      exp_blk.push_back(nblk);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Entered and left at posedge+1; the word is accepted on the edge it returns after.
   task automatic send_word(input logic [31:0] w, input bit last, input logic [2:0] nb);
      int t;
      t = 0;
      msg_word   = w;
      msg_last   = last;
      msg_nbytes = nb;
      msg_valid  = 1'b1;
      forever begin
         @(negedge clk);
         if (msg_ready) break;
         t++;
         if (t > 300) begin
            checks++;
            failures++;
            $display("FAIL msg_ready_timeout: got 0 after %0d cycles required 1", t);
            break;
         end
      end
      @(posedge clk);
      #1;
      msg_valid = 1'b0;
      msg_last  = 1'b0;
   endtask

   task automatic wait_dvalid();
      int t;
      t = 0;
      forever begin
         @(negedge clk);
         if (digest_valid) break;
         t++;
         if (t > 400) begin
            checks++;
            failures++;
            $display("FAIL digest_valid_timeout: got 0 after %0d cycles required 1", t);
            break;
         end
      end
   endtask

   task automatic handshake();
      @(posedge clk);
      #1 digest_ready = 1'b1;
      @(posedge clk);
      #1 digest_ready = 1'b0;
   endtask

   task automatic run_msg(input logic [31:0] words[$], input logic [2:0] nb, input int gapmax);
      expect_msg(words, nb);
      for (int i = 0; i < words.size(); i++) begin
         send_word(words[i], (i == words.size() - 1), nb);
         idle($urandom_range(0, gapmax));
      end
      wait_dvalid();
      idle($urandom_range(0, 3));
      handshake();
   endtask

   // Stub permutation: done pulse stub_lat cycles after the start pulse.
   initial begin
      int lat;
      stub_done = 1'b0;
      forever begin
         @(negedge clk);
         if (perm_start === 1'b1) begin
            lat = stub_lat;
            repeat (lat) @(posedge clk);
            #1 stub_done = 1'b1;
            @(posedge clk);
            #1 stub_done = 1'b0;
         end
      end
   end

   // Monitor: state at every start pulse and digest at every accept.
   initial begin
      logic [15:0][31:0] e;
      logic [255:0]      d;
      int                nb;
      forever begin
         @(negedge clk);
         if (reset === 1'b0) begin
            if (perm_start === 1'b1) begin
               blk_seen++;
               if (exp_pre.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_perm_start: got pulse required none");
               end else begin
                  e = exp_pre.pop_front();
                  chk("state_at_perm_start", perm_state_out, e);
               end
            end
            if (digest_valid === 1'b1 && digest_ready === 1'b1) begin
               if (exp_dig.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_digest: got %0h required none", digest);
               end else begin
                  d  = exp_dig.pop_front();
                  nb = exp_blk.pop_front();
                  chk("digest", digest, d);
                  chk("perm_start_count", blk_seen, nb);
               end
               blk_seen = 0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0]  w[$];
      logic [255:0] want;
      int           nw;

      reset        = 1'b1;
      msg_word     = 32'h0;
      msg_valid    = 1'b0;
      msg_last     = 1'b0;
      msg_nbytes   = 3'd0;
      digest_ready = 1'b0;
      spur_done    = 1'b0;
      stub_lat     = 3;

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_msg_ready", msg_ready, 1'b0);
      chk("rst_perm_start", perm_start, 1'b0);
      chk("rst_digest_valid", digest_valid, 1'b0);
      chk("rst_state", perm_state_out, '0);
      chk("rst_digest", digest, '0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", msg_ready, 1'b1);
      @(posedge clk);
      #1;

      // Empty message
      w.delete();
      w.push_back(32'hDEAD_BEEF);
      expect_msg(w, 3'd0);
      send_word(32'hDEAD_BEEF, 1'b1, 3'd0);
      @(negedge clk);
      chk("empty_start_pulse", perm_start, 1'b1);
      chk("empty_state0", perm_state_out[0], 32'h0600_0000);
      chk("empty_state_rest", perm_state_out[15:1], '0);
      wait_dvalid();
      want = '0;
      want[255:224] = 32'h1600_0000;
      for (int k = 1; k < 8; k++) want[255 - 32*k -: 32] = 32'h1000_0000 + 32'(k);
      chk("empty_digest_const", digest, want);
      handshake();

      // "abc"
      stub_lat = 7;
      w.delete();
      w.push_back(32'h6162_63FF);
      expect_msg(w, 3'd3);
      send_word(32'h6162_63FF, 1'b1, 3'd3);
      @(negedge clk);
      chk("abc_start_pulse", perm_start, 1'b1);
      chk("abc_state0", perm_state_out[0], 32'h6162_6306);
      wait_dvalid();
      handshake();

      // Eight full words, last n=4; digest held with spurious done in DONE
      stub_lat = 4;
      w.delete();
      for (int i = 0; i < 8; i++) w.push_back($urandom);
      expect_msg(w, 3'd4);
      for (int i = 0; i < 8; i++) send_word(w[i], (i == 7), 3'd4);
      wait_dvalid();
      @(posedge clk);
      #1 spur_done = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("hold_digest_valid", digest_valid, 1'b1);
         if (exp_dig.size() != 0) chk("hold_digest_stable", digest, exp_dig[0]);
      end
      @(posedge clk);
      #1 spur_done = 1'b0;
      handshake();

      // Last word n=4 at word 2, with spurious done during ABSORB
      stub_lat = 2;
      w.delete();
      for (int i = 0; i < 3; i++) w.push_back($urandom);
      expect_msg(w, 3'd4);
      send_word(w[0], 1'b0, 3'd0);
      send_word(w[1], 1'b0, 3'd0);
      spur_done = 1'b1;
      idle(3);
      spur_done = 1'b0;
      send_word(w[2], 1'b1, 3'd4);
      @(negedge clk);
      chk("pad_cycle_no_start", perm_start, 1'b0);
      @(negedge clk);
      chk("pad_then_start", perm_start, 1'b1);
      chk("pad_state3", perm_state_out[3], 32'h0600_0000);
      wait_dvalid();
      handshake();

      // Nine words, word held valid across the permutation; next message
      // presented together with the digest accept
      stub_lat = 6;
      w.delete();
      for (int i = 0; i < 9; i++) w.push_back($urandom);
      expect_msg(w, 3'd2);
      for (int i = 0; i < 8; i++) send_word(w[i], 1'b0, 3'd2);
      msg_word   = w[8];
      msg_last   = 1'b1;
      msg_nbytes = 3'd2;
      msg_valid  = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("ready_low_in_perm", msg_ready, 1'b0);
      end
      @(posedge clk);
      #1;
      send_word(w[8], 1'b1, 3'd2);
      wait_dvalid();
      w.delete();
      w.push_back(32'h6162_6300);
      expect_msg(w, 3'd3);
      @(posedge clk);
      #1;
      digest_ready = 1'b1;
      msg_word     = 32'h6162_6300;
      msg_last     = 1'b1;
      msg_nbytes   = 3'd3;
      msg_valid    = 1'b1;
      @(negedge clk);
      chk("no_accept_in_done", msg_ready, 1'b0);
      @(posedge clk);
      #1 digest_ready = 1'b0;
      send_word(32'h6162_6300, 1'b1, 3'd3);
      @(negedge clk);
      chk("after_done_start", perm_start, 1'b1);
      wait_dvalid();
      handshake();

      // Reset while waiting on the permutation
      stub_lat = 20;
      w.delete();
      w.push_back(32'h6162_63FF);
      expect_msg(w, 3'd3);
      send_word(32'h6162_63FF, 1'b1, 3'd3);
      idle(3);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_wait_msg_ready", msg_ready, 1'b0);
      chk("rst_wait_perm_start", perm_start, 1'b0);
      chk("rst_wait_digest_valid", digest_valid, 1'b0);
      exp_pre.delete();
      exp_dig.delete();
      exp_blk.delete();
      blk_seen = 0;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_wait_state_zero", perm_state_out, '0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_wait_ready_back", msg_ready, 1'b1);
      idle(25);
      @(negedge clk);
      chk("late_done_state_zero", perm_state_out, '0);
      chk("late_done_ready", msg_ready, 1'b1);
      chk("late_done_no_digest", digest_valid, 1'b0);
      @(posedge clk);
      #1;
      stub_lat = 5;
      w.delete();
      w.push_back(32'h6162_63FF);
      run_msg(w, 3'd3, 0);

      // Randomised messages
      for (int m = 0; m < 25; m++) begin
         w.delete();
         nw = $urandom_range(1, 20);
         for (int i = 0; i < nw; i++) w.push_back($urandom);
         stub_lat = $urandom_range(1, 20);
         run_msg(w, 3'($urandom_range(0, 7)), 2);
      end

      idle(5);
      chk("sb_digest_drained", exp_dig.size(), 0);
      chk("sb_state_drained", exp_pre.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
